// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART command-frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Frame assembly states: waiting for opcode, data high byte, data low byte.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } cmd_state_t;

  // Opcode + data high + data low.
  localparam int unsigned FRAME_BYTES = 3;

  // Default inter-byte timeout in clk cycles.
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 2000;

endpackage

// File: rtl/uart_tmo_cnt.sv
// Purpose: clear/enable up-counter with a terminal-count flag at MAX_CNT-1.
// Latency: tc is combinational from the registered count; clr/en act at the next edge.
// Backpressure: none; clr has priority over en.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count to zero at the next edge
//   en       : advance the count by one at the next edge
//   tc       : count currently equals MAX_CNT-1
module uart_tmo_cnt #(
  parameter int unsigned MAX_CNT = 2000,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(MAX_CNT - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Purpose: assemble 3-byte UART frames (opcode, data hi, data lo) into a held command.
// Latency: cmd/data/cmd_rdy update the cycle after the last byte is accepted.
// Backpressure: none toward the receiver; an unacknowledged command is overwritten and ovr is set.
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   rx_rdy, rx_data    : receiver byte available (level) and its value
//   clr_rx_rdy         : one-cycle registered acknowledge of the consumed byte
//   cmd, data          : opcode and {byte1, byte2} of the last complete frame
//   cmd_rdy            : command held and not yet acknowledged
//   clr_cmd_rdy        : consumer acknowledge of cmd_rdy
//   ovr                : sticky overwrite flag, cleared by clr_cmd_rdy
//   tmo                : one-cycle pulse when a partial frame is discarded on timeout
//   busy               : a frame is partially assembled
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        ovr,
  output logic        tmo,
  output logic        busy
);

  // Bytes that must be held until the final byte of the frame arrives.
  localparam int unsigned HOLD_BYTES = FRAME_BYTES - 1;

  cmd_state_t                  state_q, state_d;
  logic [HOLD_BYTES-1:0][7:0]  hold_q, hold_d;
  logic [7:0]                  cmd_q, cmd_d;
  logic [15:0]                 data_q, data_d;
  logic                        cmd_rdy_q, cmd_rdy_d;
  logic                        ovr_q, ovr_d;
  logic                        tmo_q, tmo_d;
  logic                        clr_rx_rdy_q, clr_rx_rdy_d;

  logic accept;
  logic waiting;
  logic tmo_hit;
  logic frame_done;
  logic cnt_tc;
  logic cnt_clr;
  logic cnt_en;

  // The receiver's rdy is still high in the cycle our clear pulse is out;
  // masking with the pulse stops the same byte being taken twice.
  assign accept  = rx_rdy & ~clr_rx_rdy_q;
  assign waiting = (state_q == WAIT_HI) || (state_q == WAIT_LO);

  // An accept on the terminal-count cycle rescues the frame.
  assign tmo_hit = waiting & ~accept & cnt_tc;

  // Counter only runs mid-frame and restarts on every accepted byte.
  assign cnt_clr = ~waiting | accept | tmo_hit;
  assign cnt_en  = waiting & ~accept;

  uart_tmo_cnt #(
    .MAX_CNT (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Frame assembly FSM.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d[0] = rx_data;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (accept) begin
          hold_d[1] = rx_data;
          state_d   = WAIT_LO;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        if (accept) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command hand-off. A completing frame beats a coincident acknowledge, and
  // in that case ovr is left alone since nothing unread was lost.
  always_comb begin
    cmd_d        = cmd_q;
    data_d       = data_q;
    cmd_rdy_d    = cmd_rdy_q;
    ovr_d        = ovr_q;
    clr_rx_rdy_d = accept;
    tmo_d        = tmo_hit;
    if (frame_done) begin
      cmd_d     = hold_q[0];
      data_d    = {hold_q[1], rx_data};
      cmd_rdy_d = 1'b1;
      if (cmd_rdy_q && !clr_cmd_rdy) begin
        ovr_d = 1'b1;
      end
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cmd_q        <= 8'h00;
      data_q       <= 16'h0000;
      cmd_rdy_q    <= 1'b0;
      ovr_q        <= 1'b0;
      tmo_q        <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      ovr_q        <= ovr_d;
      tmo_q        <= tmo_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign data       = data_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign ovr        = ovr_q;
  assign tmo        = tmo_q;
  assign busy       = waiting;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Purpose: self-checking bench for uart_cmd_ctrl against a queue-based frame model.
// Latency: model outputs are compared every cycle on the falling edge.
// Backpressure: the bench receiver holds rx_rdy until it has seen clr_rx_rdy.
module tb_uart_cmd_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        ovr;
  logic        tmo;
  logic        busy;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .ovr         (ovr),
    .tmo         (tmo),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int clr_pulses = 0;
  int tmo_pulses = 0;

  // ---------------- behavioural model ----------------
  // Partial frame is a byte queue; a frame is complete when it holds three
  // bytes. idle_run counts cycles since the last accepted byte of a frame.
  logic [7:0]  part[$];
  int          idle_run = 0;
  logic        m_clr_rx = 1'b0;
  logic        m_tmo = 1'b0;
  logic        m_cmd_rdy = 1'b0;
  logic        m_ovr = 1'b0;
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_data = 16'h0000;

  always @(posedge clk) begin
    bit took;
    bit done;
    took = rx_rdy && !m_clr_rx;
    done = 1'b0;
    if (rst) begin
      part.delete();
      idle_run  = 0;
      m_clr_rx  = 1'b0;
      m_tmo     = 1'b0;
      m_cmd_rdy = 1'b0;
      m_ovr     = 1'b0;
      m_cmd     = 8'h00;
      m_data    = 16'h0000;
    end else begin
      m_tmo = 1'b0;
      if (took) begin
        part.push_back(rx_data);
        idle_run = 0;
        if (part.size() == 3) done = 1'b1;
      end else if (part.size() != 0) begin
        idle_run++;
        if (idle_run == TMO) begin
          part.delete();
          idle_run = 0;
          m_tmo = 1'b1;
        end
      end
      if (done) begin
        if (m_cmd_rdy && !clr_cmd_rdy) m_ovr = 1'b1;
        m_cmd     = part[0];
        m_data    = {part[1], part[2]};
        m_cmd_rdy = 1'b1;
        part.delete();
      end else if (clr_cmd_rdy) begin
        m_cmd_rdy = 1'b0;
        m_ovr     = 1'b0;
      end
      m_clr_rx = took;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr_rx));
      chk("tmo", 32'(tmo), 32'(m_tmo));
      chk("cmd_rdy", 32'(cmd_rdy), 32'(m_cmd_rdy));
      chk("ovr", 32'(ovr), 32'(m_ovr));
      chk("cmd", 32'(cmd), 32'(m_cmd));
      chk("data", 32'(data), 32'(m_data));
      chk("busy", 32'(busy), 32'(part.size() != 0));
      if (clr_rx_rdy === 1'b1) clr_pulses++;
      if (tmo === 1'b1) tmo_pulses++;
    end
  endtask

  // Present one byte and hold rx_rdy until the acknowledge has been seen,
  // dropping it at the edge after the acknowledge cycle. Optionally pulse
  // clr_cmd_rdy in the same cycle the byte is offered.
  task automatic send_byte(input logic [7:0] b, input bit with_clr);
    int k;
    rx_rdy      = 1'b1;
    rx_data     = b;
    clr_cmd_rdy = with_clr;
    tick(1);
    clr_cmd_rdy = 1'b0;
    k = 0;
    while (clr_rx_rdy !== 1'b1 && k < 8) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k == 8) begin
      n_errors++;
      $display("FAIL rx_handshake: no clr_rx_rdy for byte %h within 8 cycles", b);
    end
    tick(1);
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_clr;
    int base_tmo;
    int gap;
    rst         = 1'b1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    tick(3);
    rst = 1'b0;

    chk("reset cmd", 32'(cmd), 32'h00);
    chk("reset data", 32'(data), 32'h0000);
    chk("reset cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("reset ovr", 32'(ovr), 32'h0);
    chk("reset tmo", 32'(tmo), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);

    fork
      monitor();
    join_none

    // Basic frame.
    base_clr = clr_pulses;
    send_frame(8'hA5, 8'h12, 8'h34);
    chk("frame1 clr pulses", 32'(clr_pulses - base_clr), 32'd3);
    chk("frame1 cmd", 32'(cmd), 32'hA5);
    chk("frame1 data", 32'(data), 32'h1234);
    chk("frame1 cmd_rdy", 32'(cmd_rdy), 32'h1);
    chk("frame1 busy", 32'(busy), 32'h0);
    ack_cmd();
    chk("ack cmd_rdy", 32'(cmd_rdy), 32'h0);

    // One byte consumed exactly once, then a stalled partial frame times out.
    base_clr = clr_pulses;
    base_tmo = tmo_pulses;
    send_byte(8'h01, 1'b0);
    chk("guard single pulse", 32'(clr_pulses - base_clr), 32'd1);
    send_byte(8'h02, 1'b0);
    chk("partial busy", 32'(busy), 32'h1);
    tick(TMO + 4);
    chk("timeout pulses", 32'(tmo_pulses - base_tmo), 32'd1);
    chk("timeout busy", 32'(busy), 32'h0);
    chk("timeout cmd kept", 32'(cmd), 32'hA5);
    chk("timeout cmd_rdy kept", 32'(cmd_rdy), 32'h0);
    send_frame(8'h03, 8'h04, 8'h05);
    chk("realign cmd", 32'(cmd), 32'h03);
    chk("realign data", 32'(data), 32'h0405);
    ack_cmd();

    // Overrun.
    send_frame(8'h10, 8'hAB, 8'hCD);
    send_frame(8'h20, 8'h55, 8'hAA);
    chk("ovr set", 32'(ovr), 32'h1);
    chk("ovr cmd", 32'(cmd), 32'h20);
    chk("ovr data", 32'(data), 32'h55AA);
    ack_cmd();
    chk("ovr ack cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("ovr ack ovr", 32'(ovr), 32'h0);

    // Accept exactly on the terminal-count cycle, and completion coincident
    // with acknowledge while a command is already held.
    send_frame(8'h30, 8'h01, 8'h02);
    base_tmo = tmo_pulses;
    send_byte(8'h40, 1'b0);
    tick(TMO - 2);
    send_byte(8'h41, 1'b0);
    tick(TMO - 2);
    send_byte(8'h42, 1'b1);
    chk("edge no tmo", 32'(tmo_pulses - base_tmo), 32'd0);
    chk("edge cmd", 32'(cmd), 32'h40);
    chk("edge data", 32'(data), 32'h4142);
    chk("coinc cmd_rdy", 32'(cmd_rdy), 32'h1);
    chk("coinc ovr", 32'(ovr), 32'h0);
    ack_cmd();

    // One cycle too late: the partial frame is dropped.
    base_tmo = tmo_pulses;
    send_byte(8'h50, 1'b0);
    tick(TMO - 1);
    tick(1);
    chk("late tmo", 32'(tmo_pulses - base_tmo), 32'd1);
    chk("late busy", 32'(busy), 32'h0);
    send_frame(8'h60, 8'h61, 8'h62);
    chk("late cmd", 32'(cmd), 32'h60);
    chk("late data", 32'(data), 32'h6162);

    // Reset in WAIT_LO.
    send_byte(8'h70, 1'b0);
    send_byte(8'h71, 1'b0);
    chk("pre-rst busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst cmd", 32'(cmd), 32'h00);
    chk("rst data", 32'(data), 32'h0000);
    chk("rst cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("rst ovr", 32'(ovr), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    send_frame(8'h11, 8'h22, 8'h33);
    chk("post-rst cmd", 32'(cmd), 32'h11);
    chk("post-rst data", 32'(data), 32'h2233);

    // Randomised traffic: short and near-timeout gaps, random acknowledges.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) gap = $urandom_range(TMO - 3, TMO + 3);
      else gap = $urandom_range(0, 4);
      if (gap > 0 && $urandom_range(0, 4) == 0) begin
        ack_cmd();
        gap--;
      end
      tick(gap);
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end
    tick(TMO + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
